gray_counter_n: RTL

- Parametrised up/down counter that keeps a binary count and a registered Gray-code image of it. Both images update on the same clock edge.
- Successor to the fixed 4-bit combinational binary-to-Gray converter. Adds width generality, a loadable count, binary or Gray load format, direction control and wrap/saturate handling.
- Sits at clock-domain-crossing pointer sources and position encoders. The registered Gray output can be sampled asynchronously, because it changes at most one bit per count step.

---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_to_bin_n.sv | 17 +
 rtl/gray_counter_n.sv | 84 ++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants for the Gray counter,
// pointer and synchroniser blocks.
package gray_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic logic [31:0] width_mask(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] b2g(input logic [31:0] b, input int width);
    logic [31:0] bm;
    bm = b & width_mask(width);
    return bm ^ (bm >> 1);
  endfunction

  // Prefix XOR from the MSB, done as a log-depth shift cascade; bits above
  // the width are cleared first so they cannot leak into the result.
  function automatic logic [31:0] g2b(input logic [31:0] g, input int width);
    logic [31:0] acc;
    acc = g & width_mask(width);
    for (int s = 1; s < 32; s = s * 2) begin
      acc = acc ^ (acc >> s);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gray_to_bin_n.sv
// Combinational Gray-to-binary decoder: b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i].
module gray_to_bin_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// Up/down counter holding a binary count and a registered, glitch-free Gray
// image of it; supports binary or Gray load and wrap or saturate at limits.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               SATURATE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX        = '1;
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  // One count step with limit handling; returns {wrap, next count}.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] cur,
                                          input logic dir);
    logic [WIDTH:0] res;
    res = {1'b0, cur};
    if (dir) begin
      if (cur != MAX) begin
        res = {1'b0, cur + ONE};
      end else if (SATURATE != MODE_SAT) begin
        res = {1'b1, {WIDTH{1'b0}}};
      end
    end else begin
      if (cur != '0) begin
        res = {1'b0, cur - ONE};
      end else if (SATURATE != MODE_SAT) begin
        res = {1'b1, MAX};
      end
    end
    return res;
  endfunction

  gray_to_bin_n #(
    .WIDTH(WIDTH)
  ) u_load_dec (
    .gray(load_val),
    .bin (load_bin)
  );

  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      {next_wrap, next_bin} = step(bin_q, up);
    end
  end

  // Register stage: Gray is encoded from next_bin so gray_q is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RESET_VAL;
      gray_q <= RESET_GRAY;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_bin ^ (next_bin >> 1);
      wrap   <= next_wrap;
    end
  end

  assign at_limit = up ? (&bin_q) : ~(|bin_q);

endmodule
